// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory and buffers words in a small prefetch queue that decode
// drains through a valid/ready handshake. Redirects flush the queue and reload
// the PC. Fetch stops at the end of the program image.
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int          MEM_WORDS = 65,
   parameter int          QDEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        halted_o,
   output logic [31:0] fetched_cnt_o
);

   localparam int          PW    = $clog2(QDEPTH);
   localparam logic [31:0] BOUND = 32'(MEM_WORDS * 4);
   localparam logic [PW:0] QFULL = (PW + 1)'(QDEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

   state_t        state, state_nx;
   logic [31:0]   fetch_pc, fetch_pc_nx;
   logic [31:0]   q_pc    [QDEPTH];
   logic [31:0]   q_instr [QDEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic          push, pop, flush;
   logic [31:0]   fetch_pc_inc;

   // Low two bits of the redirect target are dropped (word-aligned fetch).
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   assign fetch_pc_inc = fetch_pc + 32'd4;
   assign imem_addr_o  = fetch_pc;
   assign valid_o      = (count != '0);
   assign instr_o      = q_instr[head];
   assign pc_o         = q_pc[head];
   assign halted_o     = (state == HALT);

   // Next-state, push/pop/flush decisions; redirect outranks everything.
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      push        = 1'b0;
      flush       = 1'b0;
      pop         = valid_o & ready_i;
      if (state != IDLE && redirect_i) begin
         flush       = 1'b1;
         pop         = 1'b0;
         fetch_pc_nx = {redirect_pc_i[31:2], 2'b00};
         state_nx    = FETCH;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) state_nx = FETCH;
            end
            FETCH: begin
               if (fetch_pc >= BOUND) begin
                  state_nx = DRAIN;
               end else if (count < QFULL || pop) begin
                  push        = 1'b1;
                  fetch_pc_nx = fetch_pc_inc;
                  if (fetch_pc_inc >= BOUND) state_nx = DRAIN;
               end
            end
            DRAIN: begin
               if (count == '0 || (count == (PW + 1)'(1) && pop)) state_nx = HALT;
            end
            HALT: begin
               if (start_i) begin
                  flush       = 1'b1;
                  fetch_pc_nx = RESET_PC;
                  state_nx    = FETCH;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State, fetch PC and pushed-word counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= IDLE;
         fetch_pc      <= RESET_PC;
         fetched_cnt_o <= '0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         if (push) fetched_cnt_o <= fetched_cnt_o + 32'd1;
      end
   end

   // Prefetch queue: circular buffer with head/tail pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= imem_instr_i;
            tail          <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: reset checks, a vector table for the basic
// fetch/stall/redirect flow, hand sequences for end-of-image and mid-stream
// reset, then random traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;

   localparam logic [31:0] RPC   = 32'd0;
   localparam int          MW    = 65;
   localparam int          QD    = 2;
   localparam logic [31:0] BOUND = 32'(MW * 4);

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, redirect = 1'b0, ready = 1'b0;
   logic [31:0] rpc = '0;
   logic [31:0] imem_addr, imem_instr, instr, pc, fcnt;
   logic        valid, halted;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   // Memory image: word i holds i + 0x100.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h100;
   endfunction

   assign imem_instr = mem_word(imem_addr);

   instr_fetch_ctrl #(.RESET_PC(RPC), .MEM_WORDS(MW), .QDEPTH(QD)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .redirect_i(redirect),
      .redirect_pc_i(rpc), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
      .instr_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready),
      .halted_o(halted), .fetched_cnt_o(fcnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; redirect = 0; ready = 0; rpc = '0;
      rst_n = 0;
      #2;
      rst_n = 1;
   endtask

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_FETCH = 1, M_DRAIN = 2, M_HALT = 3;
   int          m_mode;
   logic [31:0] mq[$];
   logic [31:0] m_pc, m_cnt;

   task automatic model_reset();
      m_mode = M_IDLE; mq.delete(); m_pc = RPC; m_cnt = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      if (m_mode == M_IDLE) begin
         if (start) m_mode = M_FETCH;
      end else if (redirect) begin
         mq.delete();
         m_pc   = {rpc[31:2], 2'b00};
         m_mode = M_FETCH;
      end else begin
         if (ready && mq.size() != 0) void'(mq.pop_front());
         if (m_mode == M_FETCH) begin
            if (m_pc >= BOUND) m_mode = M_DRAIN;
            else if (mq.size() < QD) begin
               mq.push_back(m_pc);
               m_pc  = m_pc + 32'd4;
               m_cnt = m_cnt + 32'd1;
               if (m_pc >= BOUND) m_mode = M_DRAIN;
            end
         end else if (m_mode == M_DRAIN) begin
            if (mq.size() == 0) m_mode = M_HALT;
         end else if (m_mode == M_HALT && start) begin
            mq.delete();
            m_pc   = RPC;
            m_mode = M_FETCH;
         end
      end
   endtask

   task automatic model_cmp();
      chk("rnd_valid", {31'd0, valid}, {31'd0, mq.size() != 0});
      chk("rnd_halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_cnt", fcnt, m_cnt);
      if (mq.size() != 0) begin
         chk("rnd_pc", pc, mq[0]);
         chk("rnd_instr", instr, mem_word(mq[0]));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          start, redirect, ready;
      logic [31:0] rpc;
      bit          e_valid;
      logic [31:0] e_pc, e_addr, e_cnt;
   } vec_t;
   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1, 0, 1, 32'h0,  0, 32'h0,  32'h0,  32'd0};
      tbl[1] = '{0, 0, 1, 32'h0,  1, 32'h0,  32'h4,  32'd1};
      tbl[2] = '{0, 0, 1, 32'h0,  1, 32'h4,  32'h8,  32'd2};
      tbl[3] = '{0, 0, 1, 32'h0,  1, 32'h8,  32'hC,  32'd3};
      tbl[4] = '{0, 0, 0, 32'h0,  1, 32'h8,  32'h10, 32'd4};
      tbl[5] = '{0, 0, 0, 32'h0,  1, 32'h8,  32'h10, 32'd4};
      tbl[6] = '{0, 0, 1, 32'h0,  1, 32'hC,  32'h14, 32'd5};
      tbl[7] = '{0, 1, 1, 32'h23, 0, 32'h0,  32'h20, 32'd5};
      tbl[8] = '{0, 0, 1, 32'h0,  1, 32'h20, 32'h24, 32'd6};
      tbl[9] = '{1, 0, 1, 32'h0,  1, 32'h24, 32'h28, 32'd7};

      // Reset values.
      #2;
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_cnt", fcnt, 32'd0);
      tick();
      rst_n = 1;

      // Table: start, streaming, stall at full, redirect while full, start ignored.
      for (int i = 0; i < 10; i++) begin
         start = tbl[i].start; redirect = tbl[i].redirect;
         ready = tbl[i].ready; rpc = tbl[i].rpc;
         tick();
         chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_cnt", i), fcnt, tbl[i].e_cnt);
         if (tbl[i].e_valid) begin
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), instr, mem_word(tbl[i].e_pc));
         end
      end

      // Stall right after start: queue saturates at two, no loss on release.
      do_reset();
      start = 1; tick(); start = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_cnt", fcnt, 32'd2);
      chk("stall_pc", pc, 32'h0);
      ready = 1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("stall_rel_pc%0d", i), pc, 32'(i * 4));
      end

      // Run to end of image, then restart.
      begin
         logic [31:0] exp_pc, last_pc;
         int last_vcyc, hcyc;
         do_reset();
         ready = 1; start = 1; tick(); start = 0;
         exp_pc = 0; last_pc = 32'hFFFF_FFFF; last_vcyc = -10; hcyc = -1;
         for (int c = 0; c < 300 && hcyc < 0; c++) begin
            tick();
            if (halted) hcyc = c;
            else if (valid) begin
               chk("eop_pc_seq", pc, exp_pc);
               exp_pc = exp_pc + 4; last_pc = pc; last_vcyc = c;
            end
         end
         chk("eop_halt_seen", {31'd0, hcyc >= 0}, 32'd1);
         chk("eop_last_pc", last_pc, 32'h100);
         chk("eop_halt_delay", 32'(hcyc - last_vcyc), 32'd1);
         chk("eop_cnt", fcnt, 32'd65);
         chk("eop_valid", {31'd0, valid}, 32'd0);
         start = 1; tick(); start = 0;
         chk("restart_halted", {31'd0, halted}, 32'd0);
         tick();
         chk("restart_valid", {31'd0, valid}, 32'd1);
         chk("restart_pc", pc, 32'h0);
         chk("restart_cnt", fcnt, 32'd66);
      end

      // Asynchronous reset with the queue full.
      do_reset();
      start = 1; tick(); start = 0;
      tick(); tick(); tick();
      chk("mid_full_valid", {31'd0, valid}, 32'd1);
      #2 rst_n = 0;
      #1;
      chk("async_valid", {31'd0, valid}, 32'd0);
      chk("async_cnt", fcnt, 32'd0);
      chk("async_addr", imem_addr, RPC);
      rst_n = 1;
      for (int i = 0; i < 3; i++) tick();
      chk("post_rst_valid", {31'd0, valid}, 32'd0);
      chk("post_rst_addr", imem_addr, RPC);
      chk("post_rst_cnt", fcnt, 32'd0);

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         start    = ($urandom_range(0, 9) == 0);
         redirect = ($urandom_range(0, 29) == 0);
         ready    = ($urandom_range(0, 3) != 0);
         rpc      = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 280));
         model_step();
         tick();
         model_cmp();
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            model_reset();
            model_cmp();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the combinational instruction memory (word-indexed, byte address /4). It owns the fetch PC, drives the memory address and captures the returned word into a small prefetch queue. Decode drains the queue through a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC. Fetch stops cleanly at the end of the program image.

Parameters:
RESET_PC, 32'd0, fetch PC after reset and after restart from HALT
MEM_WORDS, 65, instruction memory depth in words; fetch bound = MEM_WORDS*4 bytes
QDEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  begin/restart fetching (pulse)
redirect_i  input  1  flush and reload PC (branch/jump taken)
redirect_pc_i  input  32  new fetch byte address
imem_addr_o  output  32  byte address to instruction memory (= fetch_pc)
imem_instr_i  input  32  word returned combinationally for imem_addr_o
instr_o  output  32  instruction at queue head
pc_o  output  32  byte address of instr_o
valid_o  output  1  queue head valid
ready_i  input  1  decode accepts head this cycle
halted_o  output  1  fetch finished and queue empty
fetched_cnt_o  output  32  total words pushed since reset

Behaviour:
- Reset (rst_i=0, async): state=IDLE, fetch_pc=RESET_PC, queue count=0, all queue entries 0, fetched_cnt_o=0. Outputs: instr_o=0, pc_o=0, valid_o=0, halted_o=0, imem_addr_o=RESET_PC.
- States: IDLE, FETCH, DRAIN, HALT.
  - IDLE: no push. start_i -> FETCH. redirect_i ignored.
  - FETCH:
    - push condition = (count<QDEPTH) or (pop this cycle).
    - On push: store {fetch_pc, imem_instr_i}, fetch_pc+=4, fetched_cnt_o+=1.
    - If fetch_pc+4 >= MEM_WORDS*4 after a push -> DRAIN.
    - If fetch_pc >= MEM_WORDS*4 on entry -> no push, go to DRAIN.
  - DRAIN: no push. When count reaches 0 (including via a pop this cycle) -> HALT.
  - HALT: halted_o=1. start_i -> FETCH with fetch_pc=RESET_PC and queue empty.
- Pop: occurs when valid_o & ready_i. The head advances at the clock edge; valid_o = (count!=0). instr_o/pc_o come from the registered head entry, never combinational from imem_instr_i.
- Simultaneous push and pop at full: both occur and count is unchanged.
- Redirect (FETCH/DRAIN/HALT), highest priority:
  - Queue flushed (count=0), fetch_pc = {redirect_pc_i[31:2],2'b00} (misaligned low bits dropped), state -> FETCH.
  - No push and no pop that cycle. The current head is discarded even if ready_i=1.
  - fetched_cnt_o is unchanged.
- start_i while in FETCH or DRAIN: ignored. start_i together with redirect_i in HALT: redirect wins.
- Latency: start_i sampled at edge N -> FETCH during cycle N+1, first push at edge N+2 -> valid_o=1, pc_o=RESET_PC in cycle N+2. The same one-cycle gap applies after a redirect.
- Throughput: 1 instr/cycle sustained with ready_i held at 1.
- Arithmetic: fetch_pc and fetched_cnt_o wrap modulo 2^32. The bound compare is unsigned.
- Reset asserted mid-operation: all state is lost immediately. Nothing is pushed or popped on that edge.

Test Plan:
- Reset then start_i pulse, ready_i=1, memory words i -> i+0x100: valid_o rises 2 cycles after start; pc_o sequence 0,4,8…; instr_o 0x100,0x101…; one instruction per cycle.
- ready_i=0 for 5 cycles after start: count saturates at 2, imem_addr_o holds 8. On ready_i=1, pc_o continues 0,4,8 with no loss or duplication; fetched_cnt_o=2 during the stall.
- redirect_i with redirect_pc_i=0x23 while queue is full: next cycle valid_o=0, imem_addr_o=0x20; following cycle pc_o=0x20; the old head is never accepted.
- Run to end with MEM_WORDS=65: last pc_o=0x100; halted_o=1 one cycle after that pop; fetched_cnt_o=65. Then a start_i pulse restarts fetching at pc_o=0.
- Assert rst_i=0 mid-stream with queue holding 2 entries: valid_o=0, fetched_cnt_o=0 and imem_addr_o=RESET_PC asynchronously. After release, no activity until start_i.
